// File: rtl/half_dot_v_v.sv
// Sequential binary16 dot product: one multiplier and one adder, time-shared over
// WIDTH element pairs, accumulating strictly in index order with binary16 rounding per step.

package half_fp_pkg;

  localparam logic [15:0] QNAN = 16'h7E00;

  function automatic logic [10:0] sig_of(input logic [15:0] x);
    return {|x[14:10], x[9:0]};
  endfunction

  // Exponent of the significand LSB; subnormals share the minimum normal exponent.
  function automatic int scale_of(input logic [15:0] x);
    int e;
    e = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
    return e - 25;
  endfunction

  function automatic int lead_one(input logic [47:0] v);
    int p;
    p = 0;
    for (int i = 0; i < 48; i++) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

  // Packs sig * 2^scale (sig != 0) into binary16, round-to-nearest-even,
  // overflow to infinity, gradual underflow into subnormals.
  function automatic logic [15:0] round_pack(input logic sign, input logic [47:0] sig,
                                             input int scale);
    int          p;
    int          lsb_exp;
    int          shift;
    int          e_field;
    logic [47:0] mant;
    logic        guard;
    logic        sticky;
    p       = lead_one(sig);
    lsb_exp = p + scale - 10;
    if (lsb_exp < -24) lsb_exp = -24;
    shift  = lsb_exp - scale;
    guard  = 1'b0;
    sticky = 1'b0;
    if (shift <= 0) begin
      mant = sig << (-shift);
    end else if (shift > 48) begin
      mant   = '0;
      sticky = |sig;
    end else begin
      mant   = sig >> shift;
      guard  = sig[shift-1];
      sticky = |(sig & ((48'd1 << (shift - 1)) - 48'd1));
    end
    if (guard && (sticky || mant[0])) mant = mant + 48'd1;
    if (|mant[47:11]) begin
      mant    = mant >> 1;
      lsb_exp = lsb_exp + 1;
    end
    if (mant[10]) begin
      e_field = lsb_exp + 25;
      if (e_field >= 31) return {sign, 5'h1F, 10'h000};
      return {sign, 5'(e_field), mant[9:0]};
    end
    return {sign, 5'd0, mant[9:0]};
  endfunction

  function automatic logic [15:0] mul_f(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
    logic [47:0] sig;
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    s      = a[15] ^ b[15];
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf) return {s, 5'h1F, 10'h000};
    if (a_zero || b_zero) return {s, 15'd0};
    sig = 48'(sig_of(a)) * 48'(sig_of(b));
    return round_pack(s, sig, scale_of(a) + scale_of(b));
  endfunction

  // Operands are aligned exactly (at most 29 bits of shift) before one rounding.
  // Every exactly-zero sum, including -0 + -0, comes out as +0.
  function automatic logic [15:0] add_f(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, s;
    logic [47:0] siga, sigb, sum;
    int          sca, scb, mn;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (a_nan || b_nan) return QNAN;
    if (a_inf && b_inf && (a[15] != b[15])) return QNAN;
    if (a_inf) return {a[15], 5'h1F, 10'h000};
    if (b_inf) return {b[15], 5'h1F, 10'h000};
    sca  = scale_of(a);
    scb  = scale_of(b);
    mn   = (sca < scb) ? sca : scb;
    siga = 48'(sig_of(a)) << (sca - mn);
    sigb = 48'(sig_of(b)) << (scb - mn);
    if (a[15] == b[15]) begin
      sum = siga + sigb;
      s   = a[15];
    end else if (siga >= sigb) begin
      sum = siga - sigb;
      s   = a[15];
    end else begin
      sum = sigb - siga;
      s   = b[15];
    end
    if (sum == 48'd0) return 16'h0000;
    return round_pack(s, sum, mn);
  endfunction

endpackage

// Two-stage binary16 multiplier; out_valid follows in_valid by two cycles.
module half_mul (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] result
);
  logic        v_s1;
  logic [15:0] r_s1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_s1      <= 1'b0;
      r_s1      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      v_s1      <= in_valid;
      out_valid <= v_s1;
      if (in_valid) r_s1 <= half_fp_pkg::mul_f(a, b);
      if (v_s1) result <= r_s1;
    end
  end
endmodule

// Three-stage binary16 adder; out_valid follows in_valid by three cycles.
module half_add (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] result
);
  logic        v_s1, v_s2;
  logic [15:0] r_s1, r_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_s1      <= 1'b0;
      v_s2      <= 1'b0;
      r_s1      <= '0;
      r_s2      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      v_s1      <= in_valid;
      v_s2      <= v_s1;
      out_valid <= v_s2;
      if (in_valid) r_s1 <= half_fp_pkg::add_f(a, b);
      if (v_s1) r_s2 <= r_s1;
      if (v_s2) result <= r_s2;
    end
  end
endmodule

module half_dot_v_v #(
  parameter int WIDTH = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] vector_a [WIDTH],
  input  logic [15:0] vector_b [WIDTH],
  output logic        busy,
  output logic        done,
  output logic [15:0] c
);
  localparam int             IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_REQ  = 3'd1,
    MUL_WAIT = 3'd2,
    ADD_REQ  = 3'd3,
    ADD_WAIT = 3'd4,
    NEXT     = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx;
  logic [15:0]   acc, prod, c_q;
  logic          done_q;
  logic [15:0]   a_reg [WIDTH];
  logic [15:0]   b_reg [WIDTH];
  logic          accept;

  // Handshake: a submodule samples its operands on the edge where in_valid is high;
  // out_valid is a one-cycle pulse with result valid in that same cycle.
  // At most one request is outstanding, so a pulse is only honoured in the matching WAIT state.
  logic        mul_in_valid, mul_out_valid;
  logic        add_in_valid, add_out_valid;
  logic [15:0] mul_result, add_result;

  half_mul u_mul (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (mul_in_valid),
    .a        (a_reg[idx]),
    .b        (b_reg[idx]),
    .out_valid(mul_out_valid),
    .result   (mul_result)
  );

  half_add u_add (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (add_in_valid),
    .a        (acc),
    .b        (prod),
    .out_valid(add_out_valid),
    .result   (add_result)
  );

  // The done cycle is still busy, so a start there is dropped.
  assign busy = (state != IDLE) || done_q;
  assign done = done_q;
  assign c    = c_q;

  always_comb begin
    state_d      = state;
    accept       = 1'b0;
    mul_in_valid = 1'b0;
    add_in_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done_q) begin
          accept  = 1'b1;
          state_d = MUL_REQ;
        end
      end
      MUL_REQ: begin
        mul_in_valid = 1'b1;
        state_d      = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_out_valid) state_d = (idx == '0) ? NEXT : ADD_REQ;
      end
      ADD_REQ: begin
        add_in_valid = 1'b1;
        state_d      = ADD_WAIT;
      end
      ADD_WAIT: begin
        if (add_out_valid) state_d = NEXT;
      end
      NEXT: begin
        state_d = (idx == LAST) ? IDLE : MUL_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= '0;
      prod   <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) idx <= '0;
        MUL_WAIT: begin
          if (mul_out_valid) begin
            prod <= mul_result;
            // The first product seeds the accumulator, preserving -0 and NaN payloads.
            if (idx == '0) acc <= mul_result;
          end
        end
        ADD_WAIT: if (add_out_valid) acc <= add_result;
        NEXT: begin
          if (idx == LAST) begin
            c_q    <= acc;
            done_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        a_reg[i] <= vector_a[i];
        b_reg[i] <= vector_b[i];
      end
    end
  end

endmodule

// File: tb/tb_half_dot_v_v.sv
// Directed bench for half_dot_v_v: a WIDTH=4 and a WIDTH=1 instance sharing clock and reset.
module tb_half_dot_v_v;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start4, start1;
  logic [15:0] va4 [4];
  logic [15:0] vb4 [4];
  logic [15:0] va1 [1];
  logic [15:0] vb1 [1];
  logic        busy4, done4, busy1, done1;
  logic [15:0] c4, c1;

  always #5 clk = ~clk;

  half_dot_v_v #(.WIDTH(4)) u4 (
    .clk(clk), .rstn(rstn), .start(start4), .vector_a(va4), .vector_b(vb4),
    .busy(busy4), .done(done4), .c(c4)
  );

  half_dot_v_v #(.WIDTH(1)) u1 (
    .clk(clk), .rstn(rstn), .start(start1), .vector_a(va1), .vector_b(vb1),
    .busy(busy1), .done(done1), .c(c1)
  );

  typedef struct packed {
    logic [3:0][15:0] a;   // element 0 is the rightmost field
    logic [3:0][15:0] b;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl [11];
  int   n_vec = 0;
  int   n_miss = 0;
  int   done_cnt4 = 0;
  int   add_req1 = 0;
  int   exp_done4 = 0;

  always @(negedge clk) begin
    if (done4) done_cnt4++;
    if (u1.add_in_valid) add_req1++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done4(input string name);
    int k;
    k = 0;
    while (!done4 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, 32'(done4), 32'd1);
  endtask

  task automatic run4(input string name, input logic [3:0][15:0] a, input logic [3:0][15:0] b,
                      input logic [15:0] exp);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      va4[i] = a[i];
      vb4[i] = b[i];
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      va4[i] = 16'hFFFF;
      vb4[i] = 16'hFFFF;
    end
    check({name, "_busy"}, 32'(busy4), 32'd1);
    wait_done4(name);
    exp_done4++;
    check({name, "_c"}, 32'(c4), 32'(exp));
  endtask

  task automatic run1(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
    int k;
    @(negedge clk);
    va1[0] = a;
    vb1[0] = b;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    va1[0] = 16'hFFFF;
    vb1[0] = 16'hFFFF;
    k = 0;
    while (!done1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, 32'(done1), 32'd1);
    check({name, "_c"}, 32'(c1), 32'(exp));
  endtask

  initial begin
    int k;
    tbl[0]  = '{a: {4{16'h3C00}}, b: {4{16'h4000}}, exp: 16'h4800};
    tbl[1]  = '{a: {16'h4400, 16'h4200, 16'h4000, 16'h3C00},
                b: {16'hBC00, 16'h3C00, 16'hBC00, 16'h3C00}, exp: 16'hC000};
    tbl[2]  = '{a: {4{16'h3C00}}, b: {4{16'h3C00}}, exp: 16'h4400};
    tbl[3]  = '{a: {4{16'h3C00}}, b: {4{16'h7BFF}}, exp: 16'h7C00};
    tbl[4]  = '{a: {16'h3C00, 16'h3C00, 16'h3C00, 16'h7E00}, b: {4{16'h3C00}}, exp: 16'h7E00};
    tbl[5]  = '{a: {16'h0000, 16'h0000, 16'h0000, 16'h7C00}, b: {4{16'h0000}}, exp: 16'h7E00};
    tbl[6]  = '{a: {16'h0000, 16'h0000, 16'h3C00, 16'h3C00},
                b: {16'h0000, 16'h0000, 16'hBC00, 16'h3C00}, exp: 16'h0000};
    tbl[7]  = '{a: {4{16'h0001}}, b: {4{16'h3C00}}, exp: 16'h0004};
    tbl[8]  = '{a: {16'h0000, 16'h0000, 16'h1000, 16'h3C00}, b: {4{16'h3C00}}, exp: 16'h3C00};
    tbl[9]  = '{a: {16'h0000, 16'h0000, 16'h1001, 16'h3C00}, b: {4{16'h3C00}}, exp: 16'h3C01};
    tbl[10] = '{a: {4{16'h8000}}, b: {4{16'h3C00}}, exp: 16'h0000};

    rstn   = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      va4[i] = '0;
      vb4[i] = '0;
    end
    va1[0] = '0;
    vb1[0] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_c4", 32'(c4), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_c1", 32'(c1), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run4($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp);
    end

    run1("w1_mul", 16'h4200, 16'h3800, 16'h3E00);
    run1("w1_negzero", 16'h8000, 16'h3C00, 16'h8000);
    check("w1_no_add", 32'(add_req1), 32'd0);

    // Starts on every busy cycle with different vectors must all be ignored.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      va4[i] = tbl[1].a[i];
      vb4[i] = tbl[1].b[i];
    end
    start4 = 1'b1;
    @(negedge clk);
    k = 0;
    while (!done4 && k < 300) begin
      for (int i = 0; i < 4; i++) begin
        va4[i] = tbl[0].a[i];
        vb4[i] = tbl[0].b[i];
      end
      start4 = 1'b1;
      @(negedge clk);
      k++;
    end
    exp_done4++;
    check("spam_done_seen", 32'(done4), 32'd1);
    check("spam_c", 32'(c4), 32'h0000C000);
    @(negedge clk);
    start4 = 1'b0;
    check("spam_idle_after_done", 32'(busy4), 32'd0);
    run4("after_spam", tbl[0].a, tbl[0].b, 16'h4800);

    // Reset in the middle of an accumulate step.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      va4[i] = tbl[1].a[i];
      vb4[i] = tbl[1].b[i];
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (u4.state != 3'd4 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("mid_add_wait_reached", 32'(u4.state), 32'd4);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy4), 32'd0);
    check("mid_rst_done", 32'(done4), 32'd0);
    check("mid_rst_c", 32'(c4), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run4("after_rst", tbl[0].a, tbl[0].b, 16'h4800);

    repeat (60) @(negedge clk);
    check("done_count4", 32'(done_cnt4), 32'(exp_done4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
